// File: rtl/mult_unsigned_pipe.sv
// rtl/mult_unsigned_pipe.sv - pipelined unsigned multiplier with output slice, overflow flag and valid/ready flow control
// Optional: define MULT_UNSIGNED_PIPE_SAT_EN to saturate out to all ones on overflow.
module mult_unsigned_pipe #(
    parameter int A_W     = 20,
    parameter int B_W     = 32,
    parameter int OUT_W   = 12,
    parameter int OUT_LSB = 0,
    parameter int STAGES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in1,
    input  logic [B_W-1:0]   in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_ovf,
    output logic             busy
);
    localparam int P_W = A_W + B_W;

    logic [STAGES-1:0] v;
    logic [OUT_W:0]    d [STAGES];
    logic              adv;
    logic [P_W-1:0]    prod;
    logic [P_W-1:0]    prod_shift;
    logic [OUT_W-1:0]  slice;
    logic              ovf;
    logic [OUT_W-1:0]  res;

    assign adv      = !v[STAGES-1] || out_ready;
    assign in_ready = adv;

    // Full-precision product; the trailing register stages leave room for retiming the multiply.
    assign prod       = P_W'(in1) * P_W'(in2);
    assign prod_shift = prod >> OUT_LSB;
    assign slice      = prod_shift[OUT_W-1:0];
    assign ovf        = |(prod_shift >> OUT_W);

`ifdef MULT_UNSIGNED_PIPE_SAT_EN
    assign res = ovf ? {OUT_W{1'b1}} : slice;
`else
    assign res = slice;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else if (adv) begin
            v[0] <= in_valid;
            d[0] <= {ovf, res};
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign out       = d[STAGES-1][OUT_W-1:0];
    assign out_ovf   = d[STAGES-1][OUT_W];
    assign busy      = |v;
endmodule

// File: tb/tb_mult_unsigned_pipe.sv
// tb/tb_mult_unsigned_pipe.sv - self-checking bench for mult_unsigned_pipe against a queue-based arithmetic model
module tb_mult_unsigned_pipe;
    localparam int A_W = 20, B_W = 32, OUT_W = 12, STAGES = 3;

    logic clk = 0;
    logic rst = 1;
    logic in_valid = 0;
    logic out_ready = 0;
    logic [A_W-1:0] in1 = '0;
    logic [B_W-1:0] in2 = '0;
    logic in_ready, out_valid, out_ovf, busy;
    logic [OUT_W-1:0] out;
    logic in_ready8, out_valid8, out_ovf8, busy8;
    logic [OUT_W-1:0] out8;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [OUT_W:0] r0;
        logic [OUT_W:0] r8;
    } exp_t;
    exp_t q [$];

    logic stall_prev = 0;
    logic [OUT_W+1:0] prev_out = '0;

    always #5 clk = ~clk;

    mult_unsigned_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .OUT_LSB(0), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf), .busy(busy));

    mult_unsigned_pipe #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .OUT_LSB(8), .STAGES(STAGES)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in1(in1), .in2(in2),
        .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .out_ovf(out_ovf8), .busy(busy8));

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W:0] model(input longint unsigned a, input longint unsigned b, input int lsb);
        longint unsigned p;
        logic o_ovf;
        logic [OUT_W-1:0] o;
        p = a * b;
        o_ovf = (p >> (lsb + OUT_W)) != 0;
        o = OUT_W'(p >> lsb);
`ifdef MULT_UNSIGNED_PIPE_SAT_EN
        if (o_ovf) o = '1;
`endif
        return {o_ovf, o};
    endfunction

    // Scoreboard: decides what transfers happen at the coming rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (stall_prev)
            chk("stall_stable", {out_valid, out_ovf, out}, prev_out);
        stall_prev = out_valid && !out_ready && !rst;
        prev_out = {out_valid, out_ovf, out};
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        chk("inst8_valid", out_valid8, out_valid);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out", {out_ovf, out}, e.r0);
                chk("out_lsb8", {out_ovf8, out8}, e.r8);
            end
        end
        if (rst) q.delete();
        else if (in_valid && in_ready) begin
            e.r0 = model(in1, in2, 0);
            e.r8 = model(in1, in2, 8);
            q.push_back(e);
        end
    end

    task automatic drive(input logic v, input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic r);
        @(posedge clk);
        #1;
        in_valid = v; in1 = a; in2 = b; out_ready = r;
    endtask

    task automatic single(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        drive(1, a, b, 1);
        drive(0, '0, '0, 1);
        repeat (STAGES + 1) @(posedge clk);
    endtask

    initial begin
        int lat, bcnt, vcnt, rdrop;
        // Model pinned against hand-computed values
        chk("model_3x5", model(3, 5, 0), {1'b0, 12'd15});
`ifdef MULT_UNSIGNED_PIPE_SAT_EN
        chk("model_1x4096", model(1, 4096, 0), {1'b1, 12'hFFF});
        chk("model_max_lsb8", model(20'hFFFFF, 32'hFFFFFFFF, 8), {1'b1, 12'hFFF});
`else
        chk("model_1x4096", model(1, 4096, 0), {1'b1, 12'h000});
        chk("model_max_lsb8", model(20'hFFFFF, 32'hFFFFFFFF, 8), {1'b1, 12'h000});
`endif
        chk("model_zero_lsb8", model(0, 32'hFFFFFFFF, 8), {1'b0, 12'h000});

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", {out_ovf, out}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // Latency and busy duration for a single transfer
        drive(1, 3, 5, 1);
        @(negedge clk);
        chk("accept_3x5", in_ready, 1);
        drive(0, '0, '0, 1);
        lat = 0; bcnt = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (out_valid && lat == 0) begin
                lat = n;
                chk("out_3x5", {out_ovf, out}, {1'b0, 12'd15});
            end
            if (busy) bcnt++;
        end
        chk("latency", lat, STAGES);
        chk("busy_cycles", bcnt, STAGES);

        // Back-to-back stream
        vcnt = 0; rdrop = 0;
        for (int i = 0; i < 10 + STAGES + 2; i++) begin
            if (i < 10) drive(1, A_W'(i), B_W'(i + 1), 1);
            else drive(0, '0, '0, 1);
            @(negedge clk);
            if (!in_ready) rdrop++;
            if (out_valid) vcnt++;
        end
        chk("b2b_in_ready", rdrop, 0);
        chk("b2b_results", vcnt, 10);

        single(1, 4096);
        single(20'hFFFFF, 32'hFFFFFFFF);
        single(0, 32'hFFFFFFFF);

        // Fill then stall for 5 cycles
        for (int i = 0; i < 4; i++) drive(1, A_W'($urandom), B_W'($urandom), 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, A_W'($urandom), B_W'($urandom), 0);
            @(negedge clk);
            if (i == 4) chk("stall_in_ready", in_ready, 0);
        end
        drive(0, '0, '0, 1);
        repeat (STAGES + 2) @(posedge clk);
        @(negedge clk);
        chk("stall_drained", q.size(), 0);

        // Reset with entries in flight
        for (int i = 0; i < 3; i++) drive(1, A_W'(i + 7), B_W'(i + 9), 0);
        drive(0, '0, '0, 0);
        @(negedge clk);
        chk("inflight_busy", busy, 1);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        drive(0, '0, '0, 1);
        repeat (STAGES + 2) @(posedge clk);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic [A_W-1:0] a;
            logic [B_W-1:0] b;
            case ($urandom_range(0, 3))
                0: begin a = A_W'($urandom_range(0, 255)); b = B_W'($urandom_range(0, 255)); end
                1: begin a = '1; b = B_W'($urandom); end
                default: begin a = A_W'($urandom); b = B_W'($urandom); end
            endcase
            drive($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 9) < 7);
        end

        drive(0, '0, '0, 1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("final_drain", q.size(), 0);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
